// File: rtl/aes_inv_round_ctrl.sv
// AES-128 iterative inverse cipher: one 128-bit state register, one round per clock.
// Round keys come from an external store addressed combinationally by key_idx.

module aes_inv_shift_rows (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    // Row r rotates right by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_state[8*(4*c+r) +: 8] = i_state[8*(4*((c+4-r)%4)+r) +: 8];
        end
    end
endmodule

module aes_inv_sub_bytes (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign o_state[8*i +: 8] = INV_SBOX[i_state[8*i +: 8]];
    end
endmodule

module aes_inv_mix_columns (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using its binary decomposition.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^
               (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_state[8*(4*c+r) +: 8] =
                gmul(i_state[8*(4*c+r)         +: 8], 4'he) ^
                gmul(i_state[8*(4*c+(r+1)%4)   +: 8], 4'hb) ^
                gmul(i_state[8*(4*c+(r+2)%4)   +: 8], 4'hd) ^
                gmul(i_state[8*(4*c+(r+3)%4)   +: 8], 4'h9);
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for ciphertext, initial AddRoundKey on accept
// ROUND | full inverse rounds 9..1, round counter selects the key
// FINAL | last round without InvMixColumns, key 0
// DONE  | plaintext held on data_out until out_ready
module aes_inv_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    aes_inv_shift_rows  u_isr (.i_state(r_state), .o_state(w_isr));
    aes_inv_sub_bytes   u_isb (.i_state(w_isr),   .o_state(w_isb));
    aes_inv_mix_columns u_imc (.i_state(w_ark),   .o_state(w_imc));

    assign w_ark = w_isb ^ key_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (in_valid) w_fsm_nxt = S_ROUND;
            S_ROUND: if (r_round == 4'd1) w_fsm_nxt = S_FINAL;
            S_FINAL: w_fsm_nxt = S_DONE;
            S_DONE:  if (out_ready) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // key_idx depends only on registered state so the key store path stays input-free.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        key_idx   = 4'd0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                key_idx  = 4'd10;
            end
            S_ROUND: key_idx = r_round;
            S_FINAL: key_idx = 4'd0;
            S_DONE: begin
                out_valid = 1'b1;
                key_idx   = 4'd0;
            end
            default: key_idx = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_round <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= data_in ^ key_in;
                        r_round <= 4'd9;
                    end
                end
                S_ROUND: begin
                    r_state <= w_imc;
                    r_round <= r_round - 4'd1;
                end
                S_FINAL: r_state <= w_ark;
                default: ;
            endcase
        end
    end

    assign data_out = r_state;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using the FIPS-197 C.1 AES-128 vector
// and its published key schedule as the external key store.
`timescale 1ns/1ps
module tb_aes_inv_round_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [3:0]   key_idx;

    int n_checks = 0;
    int n_fail = 0;

    logic [127:0] ct;
    logic [127:0] pt;

    always #5 clk = ~clk;

    aes_inv_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key_idx(key_idx), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    // Hex strings are written first-byte-first; the bus carries byte 0 at [7:0].
    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [3:0] idx);
        case (idx)
            4'd0:    return bswap(128'h000102030405060708090a0b0c0d0e0f);
            4'd1:    return bswap(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
            4'd2:    return bswap(128'hb692cf0b643dbdf1be9bc5006830b3fe);
            4'd3:    return bswap(128'hb6ff744ed2c2c9bf6c590cbf0469bf41);
            4'd4:    return bswap(128'h47f7f7bc95353e03f96c32bcfd058dfd);
            4'd5:    return bswap(128'h3caaa3e8a99f9deb50f3af57adf622aa);
            4'd6:    return bswap(128'h5e390f7df7a69296a7553dc10aa31f6b);
            4'd7:    return bswap(128'h14f9701ae35fe28c440adf4d4ea9c026);
            4'd8:    return bswap(128'h47438735a41c65b9e016baf4aebf7ad2);
            4'd9:    return bswap(128'h549932d1f08557681093ed9cbe2c974e);
            4'd10:   return bswap(128'h13111d7fe3944a17f307a78b4d2b30c5);
            default: return '0;
        endcase
    endfunction

    always_comb key_in = round_key(key_idx);

    task automatic start_block(input logic [127:0] d);
        @(negedge clk);
        data_in  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_done;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (key_idx !== 4'd10) begin n_fail++; $display("FAIL reset_key_idx: got %0d want 10", key_idx); end
        n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fips_vector;
        logic [3:0] exp_k;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        n_checks++; if (key_idx !== 4'd10) begin n_fail++; $display("FAIL trace_accept: got %0d want 10", key_idx); end
        data_in  = ct;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        for (int j = 1; j <= 11; j++) begin
            exp_k = (j <= 9) ? 4'(10 - j) : 4'd0;
            n_checks++;
            if (key_idx !== exp_k) begin n_fail++; $display("FAIL key_idx_trace[%0d]: got %0d want %0d", j, key_idx, exp_k); end
            n_checks++;
            if (out_valid !== (j == 11)) begin n_fail++; $display("FAIL latency[%0d]: out_valid got %b want %b", j, out_valid, (j == 11)); end
            if (j < 11) @(negedge clk);
        end
        n_checks++; if (data_out !== pt) begin n_fail++; $display("FAIL fips_plaintext: got %h want %h", data_out, pt); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (data_out !== pt) begin n_fail++; $display("FAIL bp_data_out[%0d]: got %h want %h", i, data_out, pt); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_ignored_input;
        bit ok;
        start_block(ct);
        for (int i = 0; i < 20 && key_idx != 4'd5; i++) @(negedge clk);
        n_checks++; if (key_idx !== 4'd5) begin n_fail++; $display("FAIL ign_reach_round5: got %0d want 5", key_idx); end
        data_in   = ~ct;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        n_checks++; if (key_idx !== 4'd4) begin n_fail++; $display("FAIL ign_sequence: key_idx got %0d want 4", key_idx); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b want 1", busy); end
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ign_timeout: out_valid got 0 want 1"); end
        n_checks++; if (data_out !== pt) begin n_fail++; $display("FAIL ign_plaintext: got %h want %h", data_out, pt); end
        release_done();
    endtask

    task automatic test_reset_mid;
        bit ok;
        start_block(ct);
        for (int i = 0; i < 20 && key_idx != 4'd4; i++) @(negedge clk);
        n_checks++; if (key_idx !== 4'd4) begin n_fail++; $display("FAIL rst_reach_round4: got %0d want 4", key_idx); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL rst_mid_data_out: got %h want 0", data_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_checks++; if (key_idx !== 4'd10) begin n_fail++; $display("FAIL rst_mid_key_idx: got %0d want 10", key_idx); end
        @(negedge clk);
        rst_n    = 1'b1;
        data_in  = ct;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        n_checks++; if (key_idx !== 4'd9) begin n_fail++; $display("FAIL rst_first_accept: key_idx got %0d want 9", key_idx); end
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_timeout: out_valid got 0 want 1"); end
        n_checks++; if (data_out !== pt) begin n_fail++; $display("FAIL rst_plaintext: got %h want %h", data_out, pt); end
        release_done();
    endtask

    task automatic test_back_to_back;
        int acc [2];
        int n_acc = 0;
        int n_out = 0;
        data_in   = ct;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && n_out < 2; c++) begin
            @(negedge clk);
            in_valid = (n_acc < 2);
            if (in_valid && in_ready) begin
                acc[n_acc] = c;
                n_acc++;
            end
            if (out_valid) begin
                n_checks++;
                if (data_out !== pt) begin n_fail++; $display("FAIL b2b_plaintext[%0d]: got %h want %h", n_out, data_out, pt); end
                n_out++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (n_out != 2) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 2", n_out); end
        n_checks++;
        if (n_acc != 2 || acc[1] - acc[0] != 12) begin
            n_fail++;
            $display("FAIL b2b_spacing: accepts %0d spacing %0d want 2 spacing 12", n_acc, (n_acc == 2) ? acc[1] - acc[0] : -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ct = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        pt = bswap(128'h00112233445566778899aabbccddeeff);
        test_reset();
        test_fips_vector();
        test_backpressure();
        test_ignored_input();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_inv_round_ctrl.md
AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

Interface
REQ-001 The block SHALL have no parameters; the round count is fixed at 10 (AES-128).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  ciphertext block offered.
REQ-005 in_ready  output  1  block can accept ciphertext; high only in IDLE.
REQ-006 data_in  input  128  ciphertext; byte n at bits [8n+7:8n], column-major (byte 0 = row0/col0, byte 1 = row1/col0, ...).
REQ-007 key_idx  output  4  index (0..10) of the round key the block needs this cycle.
REQ-008 key_in  input  128  round key for key_idx, combinational from the external key store, valid in the same cycle; same byte order as data_in.
REQ-009 out_valid  output  1  plaintext available on data_out.
REQ-010 out_ready  input  1  consumer accepts plaintext.
REQ-011 data_out  output  128  plaintext, same byte order; equals the state register.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL contain one 128-bit state register, one 4-bit round counter, and an FSM with states IDLE, ROUND, FINAL, DONE.
REQ-014 The block SHALL instantiate the existing InvShiftRows, InvSubBytes and InvMixColumns blocks as the combinational round datapath; no other storage is allowed.
REQ-015 IDLE: in_ready=1, key_idx=10. On in_valid, state <= data_in ^ key_in, round counter <= 9, next state ROUND.
REQ-016 ROUND: key_idx = round counter. state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key_in). The counter decrements. On the edge where the counter is 1, next state is FINAL; otherwise stay in ROUND.
REQ-017 FINAL: key_idx=0. state <= InvSubBytes(InvShiftRows(state)) ^ key_in, next state DONE.
REQ-018 DONE: out_valid=1, key_idx=0, state held. On out_ready, next state IDLE. data_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Latency: out_valid SHALL rise exactly 10 rising edges after the accepting edge (1 initial AddRoundKey + 9 ROUND + 1 FINAL edges minus the accept edge counted as the initial AddRoundKey).
REQ-020 Throughput: one block per 12 cycles minimum (accept, 9 ROUND, FINAL, DONE handshake). No overlap of blocks.
REQ-021 in_valid SHALL be ignored outside IDLE; in_ready=0 there, so no data is dropped silently.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 The same-edge DONE->IDLE transition SHALL NOT accept new input; a new block can be accepted no earlier than the next edge.
REQ-024 key_idx SHALL be a pure function of FSM state and round counter (registered sources only, no input-to-key_idx path).

Reset
REQ-025 While rst_n=0, the block SHALL force: FSM=IDLE, state register=0, round counter=0, out_valid=0, busy=0, in_ready=1, key_idx=10, data_out=0.
REQ-026 Reset asserted mid-operation (any state) SHALL abort the block immediately with no output, and the block SHALL return to the reset values above.
REQ-027 After reset deasserts, the block SHALL accept input on the first rising edge with in_valid=1.

Verification
REQ-028 FIPS-197 C.1 vector: key store loaded from key 000102030405060708090a0b0c0d0e0f; data_in = 69c4e0d86a7b0430d8cdb78070b4c55a (first byte at [7:0]) -> data_out = 00112233445566778899aabbccddeeff, with out_valid rising 10 edges after accept.
REQ-029 key_idx trace: log key_idx over one block -> sequence 10 (accept), 9,8,...,1, then 0 (FINAL), then 0 (DONE).
REQ-030 Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, data_out stays constant, in_ready stays 0; raise out_ready -> IDLE next edge.
REQ-031 Ignored input: pulse in_valid with a different block at ROUND round 5 -> no effect, and the result still matches REQ-028.
REQ-032 Reset mid-block: assert rst_n=0 during ROUND round 4 -> out_valid=0, data_out=0, busy=0 immediately; after release, a fresh REQ-028 block completes correctly.
REQ-033 Back-to-back: two blocks with in_valid and out_ready held high -> accept edges 12 cycles apart, both plaintexts correct.
